// File: rtl/hazard_stall_unit.sv
// Stall, bubble and flush control for IF/ID/EX, covering what forwarding cannot.
// Also tracks mult/div busy time, protocol errors and stall cycles.
module hazard_stall_unit #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 12,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       IFID_rs,
  input  logic [5:0]       IFID_rt,
  input  logic             IFID_uses_rt,
  input  logic             IFID_md_read,
  input  logic             IFID_md_issue,
  input  logic             IDEX_MemRd,
  input  logic             IDEX_RegWr,
  input  logic [5:0]       IDEX_rdes,
  input  logic             IDEX_md_start,
  input  logic             IDEX_md_div,
  input  logic             EX_branch_taken,
  output logic             PC_Wr,
  output logic             IFID_Wr,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             md_busy,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    IDLE,
    BUSY
  } md_state_t;

  logic [3:0] md_cnt;
  logic [3:0] md_cnt_nx;
  logic       md_err_nx;
  md_state_t  state;
  logic       load_use;
  logic       md_hazard;
  logic       stall;

  assign state   = (md_cnt != 4'd0) ? BUSY : IDLE;
  assign md_busy = (state == BUSY);

  assign load_use = IDEX_MemRd & IDEX_RegWr &
                    (IDEX_rdes != 6'd0) &
                    ((IDEX_rdes == IFID_rs) |
                     (IFID_uses_rt & (IDEX_rdes == IFID_rt)));

  assign md_hazard = md_busy & (IFID_md_read | IFID_md_issue);

  // A taken branch means ID is wrong-path, so it never stalls.
  assign stall = ~EX_branch_taken & (load_use | md_hazard);

  always_comb begin
    PC_Wr       = 1'b1;
    IFID_Wr     = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    if (reset) begin
      PC_Wr       = 1'b0;
      IFID_Wr     = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (EX_branch_taken) begin
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (stall) begin
      PC_Wr       = 1'b0;
      IFID_Wr     = 1'b0;
      IDEX_Bubble = 1'b1;
    end
  end

  always_comb begin
    md_cnt_nx = md_cnt;
    md_err_nx = md_err;
    unique case (state)
      IDLE: begin
        if (IDEX_md_start)
          md_cnt_nx = IDEX_md_div ? 4'(DIV_LAT)
                                  : 4'(MULT_LAT);
      end
      BUSY: begin
        md_cnt_nx = md_cnt - 4'd1;
        if (IDEX_md_start)
          md_err_nx = 1'b1;
      end
      default: md_cnt_nx = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt    <= 4'd0;
      md_err    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      md_cnt <= md_cnt_nx;
      md_err <= md_err_nx;
      if (stall)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed table, corner sequences
// and random traffic against a cycle-level reference model.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  IFID_rs, IFID_rt, IDEX_rdes;
  logic        IFID_uses_rt, IFID_md_read, IFID_md_issue;
  logic        IDEX_MemRd, IDEX_RegWr, IDEX_md_start, IDEX_md_div;
  logic        EX_branch_taken;
  logic        PC_Wr, IFID_Wr, IFID_Flush, IDEX_Bubble;
  logic        md_busy, md_err;
  logic [31:0] stall_cnt;

  hazard_stall_unit dut (
    .clk(clk), .reset(reset),
    .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
    .IFID_uses_rt(IFID_uses_rt),
    .IFID_md_read(IFID_md_read),
    .IFID_md_issue(IFID_md_issue),
    .IDEX_MemRd(IDEX_MemRd), .IDEX_RegWr(IDEX_RegWr),
    .IDEX_rdes(IDEX_rdes),
    .IDEX_md_start(IDEX_md_start),
    .IDEX_md_div(IDEX_md_div),
    .EX_branch_taken(EX_branch_taken),
    .PC_Wr(PC_Wr), .IFID_Wr(IFID_Wr),
    .IFID_Flush(IFID_Flush), .IDEX_Bubble(IDEX_Bubble),
    .md_busy(md_busy), .md_err(md_err),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [5:0] rs;
    logic [5:0] rt;
    logic       uses_rt;
    logic       md_read;
    logic       md_issue;
    logic       memrd;
    logic       regwr;
    logic [5:0] rdes;
    logic       md_start;
    logic       md_div;
    logic       br;
  } in_t;

  typedef struct {
    in_t        in;
    logic [3:0] exp;
  } vec_t;

  int          total  = 0;
  int          passed = 0;
  int          m_left = 0;
  logic        m_err  = 1'b0;
  logic [31:0] m_stall = '0;
  logic [3:0]  obs;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
  endtask

  function automatic in_t mk(input logic [5:0] rs, input logic [5:0] rt,
                             input logic ur, input logic mr,
                             input logic rw, input logic [5:0] rd,
                             input logic br, input logic rdmd);
    in_t v = '0;
    v.rs = rs; v.rt = rt; v.uses_rt = ur; v.memrd = mr;
    v.regwr = rw; v.rdes = rd; v.br = br; v.md_read = rdmd;
    return v;
  endfunction

  // One clock: drive, check outputs mid-cycle, advance the model.
  task automatic step(input in_t v);
    logic       lu, mh;
    logic [3:0] e;
    reset = v.rst; IFID_rs = v.rs; IFID_rt = v.rt;
    IFID_uses_rt = v.uses_rt; IFID_md_read = v.md_read;
    IFID_md_issue = v.md_issue; IDEX_MemRd = v.memrd;
    IDEX_RegWr = v.regwr; IDEX_rdes = v.rdes;
    IDEX_md_start = v.md_start; IDEX_md_div = v.md_div;
    EX_branch_taken = v.br;
    @(negedge clk);
    lu = v.memrd && v.regwr && v.rdes != 0 &&
         (v.rdes == v.rs || (v.uses_rt && v.rdes == v.rt));
    mh = (m_left > 0) && (v.md_read || v.md_issue);
    if (v.rst) e = 4'b0011;
    else if (v.br) e = 4'b1111;
    else if (lu || mh) e = 4'b0001;
    else e = 4'b1100;
    obs = {PC_Wr, IFID_Wr, IFID_Flush, IDEX_Bubble};
    chk("ctl", 32'(obs), 32'(e));
    chk("md_busy", 32'(md_busy), 32'(m_left > 0));
    chk("md_err", 32'(md_err), 32'(m_err));
    chk("stall_cnt", stall_cnt, m_stall);
    if (v.rst) begin
      m_left = 0; m_err = 1'b0; m_stall = '0;
    end else begin
      if (e == 4'b0001) m_stall = m_stall + 1;
      if (m_left > 0) begin
        if (v.md_start) m_err = 1'b1;
        m_left--;
      end else if (v.md_start) begin
        m_left = v.md_div ? 12 : 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t        tbl[11];
  in_t         v;
  logic [31:0] s0;

  initial begin
    reset = 1'b1;
    {IFID_rs, IFID_rt, IDEX_rdes} = '0;
    {IFID_uses_rt, IFID_md_read, IFID_md_issue} = '0;
    {IDEX_MemRd, IDEX_RegWr, IDEX_md_start} = '0;
    {IDEX_md_div, EX_branch_taken} = '0;
    @(posedge clk); #1;
    v = '0; v.rst = 1'b1;
    step(v);
    step(v);

    tbl[0]  = '{mk(5, 0, 0, 1, 1, 5, 0, 0), 4'b0001};
    tbl[1]  = '{mk(0, 0, 0, 1, 1, 0, 0, 0), 4'b1100};
    tbl[2]  = '{mk(1, 7, 0, 1, 1, 7, 0, 0), 4'b1100};
    tbl[3]  = '{mk(1, 7, 1, 1, 1, 7, 0, 0), 4'b0001};
    tbl[4]  = '{mk(5, 0, 0, 0, 1, 5, 0, 0), 4'b1100};
    tbl[5]  = '{mk(5, 0, 0, 1, 0, 5, 0, 0), 4'b1100};
    tbl[6]  = '{mk(5, 0, 0, 1, 1, 5, 1, 0), 4'b1111};
    tbl[7]  = '{mk(2, 3, 1, 0, 0, 4, 1, 0), 4'b1111};
    tbl[8]  = '{mk(2, 3, 1, 0, 0, 4, 0, 1), 4'b1100};
    tbl[9]  = '{mk(6, 0, 0, 1, 1, 5, 0, 0), 4'b1100};
    tbl[10] = '{mk(33, 0, 0, 1, 1, 33, 0, 0), 4'b0001};
    for (int i = 0; i < 11; i++) begin
      s0 = m_stall;
      step(tbl[i].in);
      chk($sformatf("tbl%0d", i), 32'(obs), 32'(tbl[i].exp));
      chk($sformatf("tbl%0d_cnt", i), stall_cnt,
          s0 + ((tbl[i].exp == 4'b0001) ? 32'd1 : 32'd0));
    end

    // Divide followed by mflo held in ID.
    v = '0; v.md_start = 1'b1; v.md_div = 1'b1;
    step(v);
    s0 = m_stall;
    v = '0; v.md_read = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      step(v);
      chk($sformatf("div_pc%0d", i), 32'(obs[3]), (i <= 12) ? 32'd0 : 32'd1);
    end
    chk("div_stalls", stall_cnt, s0 + 32'd12);

    // Mult, then an illegal second start.
    v = '0; v.md_start = 1'b1;
    step(v);
    step(v);
    chk("err_set", 32'(md_err), 32'd1);
    v = '0;
    for (int i = 0; i < 3; i++) step(v);
    chk("err_busy_end", 32'(md_busy), 32'd0);
    chk("err_sticky", 32'(md_err), 32'd1);

    // Reset in the middle of a divide.
    v = '0; v.md_start = 1'b1; v.md_div = 1'b1;
    step(v);
    v = '0; v.md_read = 1'b1;
    step(v);
    step(v);
    v = '0; v.rst = 1'b1; v.md_read = 1'b1;
    step(v);
    chk("rst_pc", 32'(obs), 32'b0011);
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_err", 32'(md_err), 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      v = '0;
      v.rst      = ($urandom_range(0, 79) == 0);
      v.rs       = 6'($urandom_range(0, 7));
      v.rt       = 6'($urandom_range(0, 7));
      v.rdes     = 6'($urandom_range(0, 7));
      v.uses_rt  = 1'($urandom);
      v.memrd    = 1'($urandom);
      v.regwr    = 1'($urandom);
      v.md_read  = ($urandom_range(0, 3) == 0);
      v.md_issue = ($urandom_range(0, 7) == 0);
      v.md_start = ($urandom_range(0, 9) == 0);
      v.md_div   = 1'($urandom);
      v.br       = ($urandom_range(0, 7) == 0);
      step(v);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
